apb_gpio_ctrl: RTL

Parametrised APB slave GPIO controller: NGPIO pins with per-pin output data, direction, synchronised input sampling and edge-triggered interrupts.
Sits on the APB peripheral bus next to the existing APB slaves.

---
 rtl/apb_gpio_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/apb_gpio_ctrl.sv
// APB slave GPIO controller: per-pin output data and direction, synchronised
// inputs, and edge-triggered interrupt status with enable masking.
module apb_gpio_ctrl #(
  parameter int NGPIO       = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NGPIO-1:0]  gpio_in,
  output logic [NGPIO-1:0]  gpio_out,
  output logic [NGPIO-1:0]  gpio_oe,
  output logic              irq
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  // Handshake: a transfer is SETUP (PSEL & ~PENABLE) then ACCESS
  // (PSEL & PENABLE); it completes on the rising edge where PREADY is high,
  // and PRDATA/PSLVERR are meaningful only in that cycle.
  logic             access;
  logic [2:0]       wcnt;
  logic [31:0]      addr_ext;
  logic [29:0]      word_idx;
  logic             invalid;
  logic             wr_en;
  logic [NGPIO-1:0] wdata_g;

  logic [NGPIO-1:0] data_out, dir, irq_en, irq_type, irq_stat;
  logic [NGPIO-1:0] sync1, sync2, hist;
  logic [NGPIO-1:0] edge_event;
  logic [31:0]      rdata;

  assign access   = PSEL & PENABLE;
  assign PREADY   = access & (wcnt == WS);
  assign PSLVERR  = PREADY & invalid;
  assign addr_ext = 32'(PADDR);
  assign word_idx = addr_ext[31:2];
  assign wdata_g  = PWDATA[NGPIO-1:0];
  assign wr_en    = access & PWRITE & PREADY & ~invalid;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                wcnt <= 3'd0;
    else if (access & ~PREADY) wcnt <= wcnt + 3'd1;
    else                       wcnt <= 3'd0;
  end

  always_comb begin
    invalid = 1'b1;
    if (addr_ext[1:0] == 2'b00) begin
      case (word_idx)
        30'd0, 30'd1, 30'd3, 30'd4, 30'd5: invalid = 1'b0;
        30'd2:                             invalid = PWRITE;
        default:                           invalid = 1'b1;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_event = (irq_type & ~sync2 & hist) | (~irq_type & sync2 & ~hist);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      data_out <= '0;
      dir      <= '0;
      irq_en   <= '0;
      irq_type <= '0;
    end else if (wr_en) begin
      case (word_idx)
        30'd0:   data_out <= wdata_g;
        30'd1:   dir      <= wdata_g;
        30'd3:   irq_en   <= wdata_g;
        30'd4:   irq_type <= wdata_g;
        default: ;
      endcase
    end
  end

  // A new event on a bit being cleared in the same cycle keeps the bit set.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      irq_stat <= '0;
    else if (wr_en && word_idx == 30'd5)
      irq_stat <= (irq_stat & ~wdata_g) | edge_event;
    else
      irq_stat <= irq_stat | edge_event;
  end

  always_comb begin
    rdata = 32'd0;
    if (access & ~PWRITE & ~invalid) begin
      case (word_idx)
        30'd0:   rdata[NGPIO-1:0] = data_out;
        30'd1:   rdata[NGPIO-1:0] = dir;
        30'd2:   rdata[NGPIO-1:0] = sync2;
        30'd3:   rdata[NGPIO-1:0] = irq_en;
        30'd4:   rdata[NGPIO-1:0] = irq_type;
        30'd5:   rdata[NGPIO-1:0] = irq_stat;
        default: rdata = 32'd0;
      endcase
    end
  end

  assign PRDATA   = rdata;
  assign gpio_out = data_out;
  assign gpio_oe  = dir;
  assign irq      = |(irq_stat & irq_en);

endmodule
